wb_stage: RTL
=============

Name: wb_stage

Overview:
Writeback stage (stage 5) of the RISC-V pipeline. It accepts completed instructions from the memory stage over a valid/ready handshake and formats load data (size, sign, byte lane). It then drives the single register-file write port (wr_en, stage5_rd, stage5_result). A 2-entry buffer (main + skid) absorbs write-port stalls, so in_ready is a registered signal.

Parameters:
BUS_DATA_WIDTH, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage can accept; registered
in_rd  in  5  destination register
in_rd_we  in  1  instruction writes rd
in_is_load  in  1  result comes from in_mem_rdata, else from in_alu_result
in_load_size  in  2  0=byte, 1=half, 2=word, 3=double
in_load_unsigned  in  1  zero-extend load, else sign-extend
in_addr_lo  in  3  load address bits [2:0]
in_alu_result  in  64  ALU/CSR/link result
in_mem_rdata  in  64  aligned 64-bit memory read data
wb_stall  in  1  write port unavailable this cycle
wr_en  out  1  register-file write enable
stage5_rd  out  5  write address
stage5_result  out  64  write data
retire  out  1  one instruction retires this cycle
misalign_err  out  1  retiring load was misaligned
retire_count  out  64  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset values: in_ready=1, wr_en=0, retire=0, misalign_err=0, stage5_rd=0, stage5_result=0, retire_count=0. main_valid=0, skid_valid=0.
- Accept happens when in_valid && in_ready. Formatting is done at accept time, and the formatted value is stored in the entry.
- Load formatting:
  - shifted = in_mem_rdata >> (in_addr_lo*8).
  - Take the low 8/16/32/64 bits according to size, then sign- or zero-extend to 64.
  - Double ignores unsigned.
  - Word unsigned gives upper 32 bits = 0.
- Non-load: result = in_alu_result unchanged.
- Misalignment: half with addr_lo[0]!=0, word with addr_lo[1:0]!=0, double with addr_lo!=0. The entry is stored with a mis flag. Non-loads are never misaligned.
- Drain: when main_valid && !wb_stall, the main entry retires in that cycle:
  - retire=1.
  - wr_en = rd_we && rd!=0 && !mis.
  - misalign_err = mis.
  - stage5_rd/stage5_result show the main entry whenever main_valid. When main_valid=0 they hold their last value and wr_en=0.
- When wb_stall=1: wr_en=0, retire=0, misalign_err=0, and the entry is held.
- Write latency: an instruction accepted in cycle N with main free or draining writes in cycle N+1 if wb_stall=0.
- Buffer update per cycle, where drain = main_valid && !wb_stall:
  - skid_valid && drain: skid moves to main. A new accept in the same cycle goes to skid.
  - !skid_valid: an accept goes to main if (!main_valid || drain), otherwise to skid.
  - No entry is ever lost or reordered.
- in_ready next = !(skid_valid_next). It may still be high while main is stalled; the skid holds the one extra item.
- rd=0 retires normally (retire=1) but never asserts wr_en.
- Reset mid-operation discards both entries. No write occurs in the reset cycle or the following cycle.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: retire_count is a 64-bit counter, incremented by 1 on every cycle with retire=1 (including misaligned and rd=0). It is cleared by reset and wraps from 2^64-1 to 0.
- Undefined: retire_count is tied to 0 and no counter flops exist.

Test Plan:
1. Reset asserted 2 cycles, then released -> in_ready=1, wr_en=0, retire=0, retire_count=0.
2. Signed byte load at addr_lo=0, mem_rdata=0x1122334455667788 -> next cycle wr_en=1, stage5_result=0xFFFFFFFFFFFFFF88. Same load unsigned -> 0x88. Half at addr_lo=6 signed -> 0x0000000000001122.
3. ALU op with rd=0, alu_result=0xDEAD -> retire=1, wr_en=0. Same with rd=5 -> wr_en=1, stage5_rd=5, stage5_result=0xDEAD.
4. wb_stall=1 for 3 cycles while feeding A,B,C back-to-back -> A held in main, B in skid, in_ready=0 from the cycle after B. C is held upstream. After stall release, writes occur in order A,B,C on consecutive cycles. With WB_RETIRE_CNT_EN, retire_count=3.
5. Half load at addr_lo=1, rd=7 -> retire=1, misalign_err=1 for one cycle, wr_en=0.
6. Two entries buffered under stall, then reset pulsed -> no wr_en thereafter, in_ready=1, retire_count=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: formats load data, buffers up to two completed instructions
// (main + skid) and drives the register-file write port. Optional macro: WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_rd,
    input  logic                      in_rd_we,
    input  logic                      in_is_load,
    input  logic [1:0]                in_load_size,
    input  logic                      in_load_unsigned,
    input  logic [2:0]                in_addr_lo,
    input  logic [BUS_DATA_WIDTH-1:0] in_alu_result,
    input  logic [BUS_DATA_WIDTH-1:0] in_mem_rdata,
    input  logic                      wb_stall,
    output logic                      wr_en,
    output logic [4:0]                stage5_rd,
    output logic [BUS_DATA_WIDTH-1:0] stage5_result,
    output logic                      retire,
    output logic                      misalign_err,
    output logic [63:0]               retire_count
);

    typedef struct packed {
        logic [4:0]                rd;
        logic                      rd_we;
        logic                      mis;
        logic [BUS_DATA_WIDTH-1:0] result;
    } entry_t;

    entry_t                    main_q, main_d, skid_q, skid_d, new_e;
    logic                      main_valid_q, main_valid_d;
    logic                      skid_valid_q, skid_valid_d;
    logic                      in_ready_q;
    logic [4:0]                last_rd_q;
    logic [BUS_DATA_WIDTH-1:0] last_res_q;
    logic [BUS_DATA_WIDTH-1:0] shifted, ld_val;
    logic                      ld_mis, accept, drain;

    // Load formatting happens at accept so the buffers hold final write data.
    always_comb begin
        shifted = in_mem_rdata >> {in_addr_lo, 3'b000};
        ld_val  = shifted;
        ld_mis  = 1'b0;
        case (in_load_size)
            2'd0: ld_val = in_load_unsigned ? {56'b0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
            2'd1: begin
                ld_val = in_load_unsigned ? {48'b0, shifted[15:0]}
                                          : {{48{shifted[15]}}, shifted[15:0]};
                ld_mis = in_addr_lo[0];
            end
            2'd2: begin
                ld_val = in_load_unsigned ? {32'b0, shifted[31:0]}
                                          : {{32{shifted[31]}}, shifted[31:0]};
                ld_mis = |in_addr_lo[1:0];
            end
            default: begin
                ld_val = shifted;
                ld_mis = |in_addr_lo;
            end
        endcase
        new_e.rd     = in_rd;
        new_e.rd_we  = in_rd_we;
        new_e.mis    = in_is_load && ld_mis;
        new_e.result = in_is_load ? ld_val : in_alu_result;
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = main_valid_q && !wb_stall;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q && !drain;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (drain) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = new_e;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_d       = new_e;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_e;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            last_rd_q    <= '0;
            last_res_q   <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            if (main_valid_q) begin
                last_rd_q  <= main_q.rd;
                last_res_q <= main_q.result;
            end
        end
    end

    // Outputs are masked during reset so a buffered entry cannot write in that cycle.
    assign in_ready      = in_ready_q;
    assign retire        = drain && !reset;
    assign misalign_err  = retire && main_q.mis;
    assign wr_en         = retire && main_q.rd_we && (main_q.rd != 5'd0) && !main_q.mis;
    assign stage5_rd     = main_valid_q ? main_q.rd : last_rd_q;
    assign stage5_result = main_valid_q ? main_q.result : last_res_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset)       cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + 64'd1;
    end
    assign retire_count = cnt_q;
`else
    assign retire_count = '0;
`endif

endmodule
